// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer and the control
// unit that drives it.
package muldiv_pkg;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;

  // Implementation-specific Cause ExcCode the control unit raises on div_zero.
  localparam logic [4:0] CAUSE_DIV_ZERO = 5'd16;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Magnitude of a signed word; 0x80000000 maps onto itself as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = neg32(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine: one shift-add or restoring-subtract step per
// cycle on unsigned magnitudes, sign fix-up at the end, owns HI/LO.
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [2:0]  state_out
);
  import muldiv_pkg::*;

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  muldiv_state_t    state_r, state_s;
  muldiv_op_t       op_r;
  logic [31:0]      a_r, b_r;
  logic [31:0]      opa_r, opb_r;
  logic [63:0]      acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_q_r, sign_r_r;
  logic [31:0]      hi_r, lo_r;
  logic             busy_r, done_r, div_zero_r;

  logic             b_zero_s;
  logic [32:0]      mul_sum_s;
  logic [32:0]      div_rem_s;
  logic [33:0]      div_diff_s;
  logic [63:0]      step_acc_s;
  logic [63:0]      prod_s;
  logic [31:0]      quo_s, rem_s;

  assign b_zero_s = (b_r == 32'h0000_0000);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = PREP;
        end else begin
          state_s = IDLE;
        end
      end
      PREP: begin
        if ((op_r == OP_DIV) && b_zero_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One iteration: multiply consumes opb_r LSB-first, divide consumes opa_r MSB-first.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[63:32]} + (opb_r[0] ? {1'b0, opa_r} : 33'd0);
    div_rem_s  = {acc_r[63:32], opa_r[31]};
    div_diff_s = {1'b0, div_rem_s} - {2'b00, opb_r};
    if (op_r == OP_MULT) begin
      step_acc_s = {mul_sum_s, acc_r[31:1]};
    end else if (!div_diff_s[33]) begin
      step_acc_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
    end else begin
      step_acc_s = {div_rem_s[31:0], acc_r[30:0], 1'b0};
    end
  end

  // Sign correction of the unsigned magnitudes held in the accumulator.
  always_comb begin
    if (sign_q_r) begin
      prod_s = neg64(acc_r);
      quo_s  = neg32(acc_r[31:0]);
    end else begin
      prod_s = acc_r;
      quo_s  = acc_r[31:0];
    end
    if (sign_r_r) begin
      rem_s = neg32(acc_r[63:32]);
    end else begin
      rem_s = acc_r[63:32];
    end
  end

  // Datapath, HI/LO and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r       <= OP_MULT;
      a_r        <= 32'h0000_0000;
      b_r        <= 32'h0000_0000;
      opa_r      <= 32'h0000_0000;
      opb_r      <= 32'h0000_0000;
      acc_r      <= 64'h0;
      cnt_r      <= {CNT_W{1'b0}};
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      hi_r       <= 32'h0000_0000;
      lo_r       <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r       <= muldiv_op_t'(op);
            a_r        <= a;
            b_r        <= b;
            div_zero_r <= 1'b0;
          end
          if (hi_we) begin
            hi_r <= wdata;
          end
          if (lo_we) begin
            lo_r <= wdata;
          end
        end
        PREP: begin
          sign_q_r   <= a_r[31] ^ b_r[31];
          sign_r_r   <= a_r[31];
          opa_r      <= abs32(a_r);
          opb_r      <= abs32(b_r);
          acc_r      <= 64'h0;
          cnt_r      <= {CNT_W{1'b0}};
          div_zero_r <= (op_r == OP_DIV) && b_zero_s;
        end
        RUN: begin
          acc_r <= step_acc_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (op_r == OP_MULT) begin
            opb_r <= {1'b0, opb_r[31:1]};
          end else begin
            opa_r <= {opa_r[30:0], 1'b0};
          end
        end
        FIX: begin
          if (op_r == OP_MULT) begin
            hi_r <= prod_s[63:32];
            lo_r <= prod_s[31:0];
          end else begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end
        end
        DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign div_zero  = div_zero_r;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign state_out = state_r;

endmodule
